// File: rtl/accumulator_sequencer.sv
// Control block of the 8-bit accumulator core: fetch/decode/execute sequencing,
// PC/IR/MDR/ACC/flag ownership, and req/ack handshakes to instruction and data memory.
module accumulator_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        imem_req_o,
  output logic [7:0]  imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [11:0] imem_data_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [7:0]  dmem_addr_o,
  output logic [7:0]  dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [7:0]  dmem_rdata_i,
  output logic [2:0]  alu_func_o,
  output logic [7:0]  alu_a_imm_o,
  output logic [7:0]  alu_a_mem_o,
  output logic [7:0]  alu_b_o,
  input  logic [7:0]  alu_result_i,
  input  logic        alu_fz_i,
  input  logic        alu_fc_i,
  output logic [7:0]  acc_o,
  output logic        fz_o,
  output logic        fc_o,
  output logic        halted_o
);

  localparam int unsigned DW = 8;
  localparam int unsigned IW = 12;

  localparam logic [3:0] OP_ADI = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h8;
  localparam logic [3:0] OP_STA = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_JZ  = 4'hB;
  localparam logic [3:0] OP_JC  = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hE;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_RD,
    S_MEM_WR,
    S_EXEC,
    S_WB_LD,
    S_HALT
  } state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  pc_q, pc_d;
  logic [IW-1:0]  ir_q, ir_d;
  logic [DW-1:0]  mdr_q, mdr_d;
  logic [DW-1:0]  acc_q, acc_d;
  logic           fz_q, fz_d;
  logic           fc_q, fc_d;
  logic           imem_req_q;
  logic           dmem_req_q;
  logic           dmem_we_q;
  logic           halted_q;

  logic [3:0]     opcode;
  logic [DW-1:0]  operand;

  assign opcode  = ir_q[11:8];
  assign operand = ir_q[7:0];

  // Next-state and datapath update; a handshake only completes while its req is up
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    acc_d   = acc_q;
    fz_d    = fz_q;
    fc_d    = fc_q;
    case (state_q)
      S_FETCH: begin
        if (imem_req_q && imem_ack_i) begin
          ir_d    = imem_data_i;
          pc_d    = pc_q + DW'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_ADI: state_d = S_EXEC;
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, OP_LDA: state_d = S_MEM_RD;
          OP_STA: state_d = S_MEM_WR;
          OP_JMP: begin
            pc_d    = operand;
            state_d = S_FETCH;
          end
          OP_JZ: begin
            if (fz_q) pc_d = operand;
            state_d = S_FETCH;
          end
          OP_JC: begin
            if (fc_q) pc_d = operand;
            state_d = S_FETCH;
          end
          OP_HLT: state_d = S_HALT;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM_RD: begin
        if (dmem_req_q && dmem_ack_i) begin
          mdr_d   = dmem_rdata_i;
          state_d = (opcode == OP_LDA) ? S_WB_LD : S_EXEC;
        end
      end
      S_MEM_WR: begin
        if (dmem_req_q && dmem_ack_i) state_d = S_FETCH;
      end
      S_EXEC: begin
        acc_d   = alu_result_i;
        fz_d    = alu_fz_i;
        fc_d    = alu_fc_i;
        state_d = S_FETCH;
      end
      S_WB_LD: begin
        acc_d   = mdr_q;
        fz_d    = (mdr_q == DW'(0));
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // State/datapath registers; request strobes are registered from the next state
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      mdr_q      <= '0;
      acc_q      <= '0;
      fz_q       <= 1'b0;
      fc_q       <= 1'b0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      mdr_q      <= mdr_d;
      acc_q      <= acc_d;
      fz_q       <= fz_d;
      fc_q       <= fc_d;
      imem_req_q <= (state_d == S_FETCH);
      dmem_req_q <= (state_d == S_MEM_RD) || (state_d == S_MEM_WR);
      dmem_we_q  <= (state_d == S_MEM_WR);
      halted_q   <= (state_d == S_HALT);
    end
  end

  assign imem_req_o   = imem_req_q;
  assign imem_addr_o  = pc_q;
  assign dmem_req_o   = dmem_req_q;
  assign dmem_we_o    = dmem_we_q;
  assign dmem_addr_o  = operand;
  assign dmem_wdata_o = acc_q;
  assign alu_func_o   = opcode[2:0];
  assign alu_a_imm_o  = operand;
  assign alu_a_mem_o  = mdr_q;
  assign alu_b_o      = acc_q;
  assign acc_o        = acc_q;
  assign fz_o         = fz_q;
  assign fc_o         = fc_q;
  assign halted_o     = halted_q;

endmodule

// File: doc/accumulator_sequencer.md
Name: accumulator_sequencer

Overview:
Fetch/decode/execute sequencer sitting directly upstream of the alu: owns PC, instruction register, accumulator and flag registers. Drives the alu operand/function inputs, and captures result_o/fz_o/fc_o back into ACC and the flags. Talks to instruction memory and data memory through req/ack handshakes. It is the single control block of the 8-bit accumulator core.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset
(ACC, alu and data path widths are fixed at 8 bits; instruction width is fixed at 12 bits.)

Ports:
clk_i  in  1  core clock; all state changes on rising edge
rst_n_i  in  1  reset, synchronous, active-low
imem_req_o  out  1  instruction fetch request
imem_addr_o  out  8  fetch address (= PC)
imem_ack_i  in  1  fetch complete; imem_data_i valid this cycle
imem_data_i  in  12  instruction: opcode [11:8], operand [7:0]
dmem_req_o  out  1  data access request
dmem_we_o  out  1  1 = write, 0 = read
dmem_addr_o  out  8  data address (= IR operand)
dmem_wdata_o  out  8  write data (= ACC)
dmem_ack_i  in  1  access complete; dmem_rdata_i valid this cycle on a read
dmem_rdata_i  in  8  read data
alu_func_o  out  3  to alu func_i (= opcode[2:0])
alu_a_imm_o  out  8  to alu a_imm_i (= IR operand)
alu_a_mem_o  out  8  to alu a_mem_i (= MDR)
alu_b_o  out  8  to alu b_i (= ACC)
alu_result_i  in  8  from alu result_o
alu_fz_i  in  1  from alu fz_o
alu_fc_i  in  1  from alu fc_o
acc_o  out  8  accumulator value
fz_o  out  1  registered zero flag
fc_o  out  1  registered carry flag
halted_o  out  1  high while in HALT

Behaviour:
- Reset (rst_n_i low at edge): PC=RESET_PC, IR=0, MDR=0, ACC=0, fz=0, fc=0, state=FETCH. All req outputs are 0 from the cycle after the reset edge, and halted_o=0. Reset mid-handshake abandons the access; late acks are ignored because req is low.
- Opcodes: 0x0 ADI (alu func 000, immediate operand); 0x1-0x7 ADD/SUB/AND/ORR/XOR/LSL/LSR (func = opcode[2:0], memory operand); 0x8 LDA; 0x9 STA; 0xA JMP; 0xB JZ; 0xC JC; 0xD/0xF NOP; 0xE HLT.
- FETCH: imem_req_o=1, imem_addr_o=PC. req is held until imem_ack_i. On the ack cycle: IR<=imem_data_i, PC<=PC+1 (mod 256, 0xFF wraps to 0x00), go DECODE.
- DECODE (1 cycle):
  - ADI: go EXEC.
  - ALU-mem ops and LDA: go MEM_RD.
  - STA: go MEM_WR.
  - JMP: PC<=operand. JZ/JC: PC<=operand if fz/fc is set, else PC unchanged. All jumps then go FETCH.
  - NOP: go FETCH. HLT: go HALT.
- MEM_RD: dmem_req_o=1, dmem_we_o=0, addr=operand. On ack: MDR<=dmem_rdata_i. LDA goes WB_LD; ALU ops go EXEC.
- MEM_WR: dmem_req_o=1, dmem_we_o=1, wdata=ACC. On ack go FETCH. ACC and flags are unchanged.
- EXEC (1 cycle): ACC<=alu_result_i, fz<=alu_fz_i, fc<=alu_fc_i; go FETCH.
- WB_LD (1 cycle): ACC<=MDR, fz<=(MDR==0), fc unchanged; go FETCH.
- HALT: terminal until reset. No reqs, halted_o=1, all registers frozen.
- The alu ports are driven combinationally from IR/MDR/ACC in every state; only EXEC samples the alu outputs.
- Latency with zero-wait acks (ack in same cycle as req):
  - ADI: 3 cycles. ALU-mem ops: 4. LDA: 4. STA: 3.
  - JMP/JZ/JC/NOP: 2.
- Req/address stability: req and address stay stable while waiting for ack. An ack while req is low is ignored.

Test Plan:
- Reset, then program ADI 0x05; ADI 0xFB with zero-wait memories -> after 6 cycles ACC=0x00, fz=1, fc=1 (8-bit overflow), PC=0x02.
- LDA 0x10 (mem[0x10]=0x0C); LSL 0x10 -> ACC=0x0C after LDA. After LSL, ACC=0x18 and fz=0.
- STA 0x20 with ACC=0x3C and dmem_ack delayed 3 cycles -> dmem_req_o/we_o/addr/wdata held stable 4 cycles. Single write of 0x3C to 0x20; ACC and flags unchanged.
- With fz=1: JZ 0x40 -> next imem_addr_o=0x40. Same instruction with fz=0 -> next fetch at PC+1. JC follows fc in the same way.
- PC=0xFF executing NOP -> next fetch address 0x00. HLT -> halted_o=1, no further req for 20 cycles.
- Assert rst_n_i during a stalled MEM_RD (no ack) -> next cycle dmem_req_o=0. Registers are at reset values, and fetch restarts at RESET_PC.
